// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the store buffer: the default depth, the pointer width
// and the entry record (word address + data).
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);
  localparam int SB_CNT_W  = SB_PTR_W + 1;

  typedef struct packed {
    logic [SB_ADDR_W-3:0] waddr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Word-address comparators over the occupied FIFO slots. The slot closest to the
// tail (youngest) wins when several pending stores hit the same word.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic [PTR_W-1:0]     head,
  input  logic [CNT_W-1:0]     count,
  input  sb_entry_t            entries [DEPTH],
  input  logic [SB_ADDR_W-3:0] ld_waddr,
  output logic                 match,
  output logic [PTR_W-1:0]     match_idx
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so a later hit overrides an earlier one.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    slot      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[slot].waddr == ld_waddr)) begin
        match     = 1'b1;
        match_idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer that drains into the memory write port whenever no load needs
// the shared address bus. Define STORE_BUF_FWD_EN to forward pending data to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  input  logic              fence,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] to_be_written_data,
  output logic              MemWrite
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a store transfers on a rising edge where st_valid && st_ready; st_ready
  // depends only on occupancy and fence, never on st_valid.
  sb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             push, pop;
  logic             match;
  logic [PTR_W-1:0] match_idx;
  logic             ld_match;
  logic             unused_addr_bits;

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != CNT_W'(DEPTH)) && !fence;
  assign push     = st_valid && st_ready;
  assign pop      = MemWrite;

  store_buffer_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_match (
    .head      (head_q),
    .count     (count_q),
    .entries   (entries_q),
    .ld_waddr  (ld_addr[ADDR_W-1:2]),
    .match     (match),
    .match_idx (match_idx)
  );

  assign ld_match = ld_req && match;

`ifdef STORE_BUF_FWD_EN
  assign ld_hit   = ld_match;
  assign ld_data  = ld_match ? entries_q[match_idx].data : '0;
  assign ld_stall = 1'b0;
`else
  logic unused_match_idx;
  assign unused_match_idx = ^match_idx;
  // Hold the load while the hitting stores drain; the drain itself clears the hit.
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
  assign ld_stall = ld_match;
`endif

  assign MemWrite           = !empty && (!ld_req || ld_stall);
  assign to_be_written_data = MemWrite ? entries_q[head_q].data : '0;

  always_comb begin
    mem_adr = '0;
    if (ld_req && !ld_stall) begin
      mem_adr = ld_addr;
    end else if (!empty) begin
      mem_adr = {entries_q[head_q].waddr, 2'b00};
    end
  end

  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload needs no reset: slots outside head..count are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q].waddr <= st_addr[ADDR_W-1:2];
      entries_q[tail_q].data  <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order, backpressure, fence, forwarding or
// stall (follows STORE_BUF_FWD_EN), pointer wrap and asynchronous reset.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              st_valid, ld_req, fence;
  logic [ADDR_W-1:0] st_addr, ld_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready, ld_hit, ld_stall, empty, MemWrite;
  logic [DATA_W-1:0] ld_data, to_be_written_data;
  logic [ADDR_W-1:0] mem_adr;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .st_valid           (st_valid),
    .st_addr            (st_addr),
    .st_data            (st_data),
    .st_ready           (st_ready),
    .ld_req             (ld_req),
    .ld_addr            (ld_addr),
    .ld_hit             (ld_hit),
    .ld_data            (ld_data),
    .ld_stall           (ld_stall),
    .fence              (fence),
    .empty              (empty),
    .mem_adr            (mem_adr),
    .to_be_written_data (to_be_written_data),
    .MemWrite           (MemWrite)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write seen mid-cycle commits on the next rising edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && MemWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {63'd0, MemWrite}, 64'd0);
      end else begin
        check_eq("mem_write", {mem_adr, to_be_written_data}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_req = 1'b0; ld_addr = '0; fence = 1'b0;
  endtask

  task automatic put_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    exp_q.push_back({a[ADDR_W-1:2], 2'b00, d});
  endtask

  task automatic drain_all(input int budget);
    st_valid = 1'b0;
    ld_req   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (empty === 1'b1) break;
      tick();
    end
    @(negedge clk);
    check_eq("drain_empty", {63'd0, empty}, 64'd1);
    check_eq("drain_left", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int model_cnt;
    int sent;
    logic exp_ready, exp_wr;

    // reset values
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_st_ready", {63'd0, st_ready}, 64'd1);
    check_eq("rst_memwrite", {63'd0, MemWrite}, 64'd0);
    check_eq("rst_empty", {63'd0, empty}, 64'd1);
    check_eq("rst_ld_hit", {63'd0, ld_hit}, 64'd0);
    check_eq("rst_ld_data", 64'(ld_data), 64'd0);
    check_eq("rst_ld_stall", {63'd0, ld_stall}, 64'd0);
    check_eq("rst_mem_adr", 64'(mem_adr), 64'd0);
    check_eq("rst_wdata", 64'(to_be_written_data), 64'd0);
    tick();
    rst_n = 1'b1;

    // three back-to-back stores, no loads: writes on the three following cycles
    put_store(32'h1000, 32'h1111_0000);
    @(negedge clk);
    check_eq("t1_ready", {63'd0, st_ready}, 64'd1);
    check_eq("t1_nowr_first", {63'd0, MemWrite}, 64'd0);
    tick();
    put_store(32'h1004, 32'h1111_0004);
    @(negedge clk);
    check_eq("t1_wr_c2", {63'd0, MemWrite}, 64'd1);
    check_eq("t1_adr_c2", 64'(mem_adr), 64'h1000);
    tick();
    put_store(32'h1008, 32'h1111_0008);
    @(negedge clk);
    check_eq("t1_wr_c3", {63'd0, MemWrite}, 64'd1);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_wr_c4", {63'd0, MemWrite}, 64'd1);
    check_eq("t1_adr_c4", 64'(mem_adr), 64'h1008);
    tick();
    @(negedge clk);
    check_eq("t1_empty", {63'd0, empty}, 64'd1);
    check_eq("t1_idle_wr", {63'd0, MemWrite}, 64'd0);
    check_eq("t1_idle_adr", 64'(mem_adr), 64'd0);
    tick();

    // fill while loads hold the bus; fifth attempt is refused
    ld_req  = 1'b1;
    ld_addr = 32'h9000;
    for (int i = 0; i < DEPTH; i++) begin
      put_store(32'h3000 + 32'(4 * i), 32'h3333_0000 + 32'(i));
      @(negedge clk);
      check_eq("t2_fill_ready", {63'd0, st_ready}, 64'd1);
      check_eq("t2_fill_nowr", {63'd0, MemWrite}, 64'd0);
      check_eq("t2_load_adr", 64'(mem_adr), 64'h9000);
      tick();
    end
    st_valid = 1'b1;
    st_addr  = 32'h3010;
    st_data  = 32'hdead_0005;
    @(negedge clk);
    check_eq("t2_full_ready", {63'd0, st_ready}, 64'd0);
    check_eq("t2_full_nowr", {63'd0, MemWrite}, 64'd0);
    tick();
    st_valid = 1'b0;
    ld_req   = 1'b0;
    @(negedge clk);
    check_eq("t2_drain_wr", {63'd0, MemWrite}, 64'd1);
    check_eq("t2_still_full", {63'd0, st_ready}, 64'd0);
    tick();
    @(negedge clk);
    check_eq("t2_ready_back", {63'd0, st_ready}, 64'd1);
    tick();
    drain_all(10);

    // fence blocks new stores in the same cycle, drain continues
    put_store(32'h5000, 32'h5555_0000);
    tick();
    st_valid = 1'b0;
    fence    = 1'b1;
    @(negedge clk);
    check_eq("fence_ready", {63'd0, st_ready}, 64'd0);
    check_eq("fence_drain", {63'd0, MemWrite}, 64'd1);
    tick();
    @(negedge clk);
    check_eq("fence_empty", {63'd0, empty}, 64'd1);
    check_eq("fence_hold", {63'd0, st_ready}, 64'd0);
    tick();
    fence = 1'b0;
    @(negedge clk);
    check_eq("fence_release", {63'd0, st_ready}, 64'd1);
    tick();

    // two stores to one word, then a load to that word
    ld_req  = 1'b1;
    ld_addr = 32'h9000;
    put_store(32'h2000, 32'h0000_aaaa);
    tick();
    put_store(32'h2000, 32'h0000_bbbb);
    tick();
    st_valid = 1'b0;
    ld_addr  = 32'h2002;
`ifdef STORE_BUF_FWD_EN
    @(negedge clk);
    check_eq("fwd_hit", {63'd0, ld_hit}, 64'd1);
    check_eq("fwd_data", 64'(ld_data), 64'h0000_bbbb);
    check_eq("fwd_stall", {63'd0, ld_stall}, 64'd0);
    check_eq("fwd_nowr", {63'd0, MemWrite}, 64'd0);
    check_eq("fwd_adr", 64'(mem_adr), 64'h2002);
    tick();
    ld_addr = 32'h2004;
    @(negedge clk);
    check_eq("fwd_miss_hit", {63'd0, ld_hit}, 64'd0);
    check_eq("fwd_miss_data", 64'(ld_data), 64'd0);
    tick();
    drain_all(10);
`else
    @(negedge clk);
    check_eq("stall_c1", {63'd0, ld_stall}, 64'd1);
    check_eq("stall_c1_hit", {63'd0, ld_hit}, 64'd0);
    check_eq("stall_c1_wr", {63'd0, MemWrite}, 64'd1);
    check_eq("stall_c1_adr", 64'(mem_adr), 64'h2000);
    tick();
    @(negedge clk);
    check_eq("stall_c2", {63'd0, ld_stall}, 64'd1);
    check_eq("stall_c2_wdata", 64'(to_be_written_data), 64'h0000_bbbb);
    tick();
    @(negedge clk);
    check_eq("stall_done", {63'd0, ld_stall}, 64'd0);
    check_eq("stall_load_adr", 64'(mem_adr), 64'h2002);
    check_eq("stall_done_nowr", {63'd0, MemWrite}, 64'd0);
    check_eq("stall_empty", {63'd0, empty}, 64'd1);
    tick();
    ld_req = 1'b0;
    drain_all(4);
`endif

    // ten stores with intermittent loads: pointer wrap and full-buffer refusals
    model_cnt = 0;
    sent      = 0;
    for (int cyc = 0; cyc < 60 && sent < 10; cyc++) begin
      ld_req    = (cyc % 3 != 0);
      ld_addr   = 32'h9000;
      st_valid  = 1'b1;
      st_addr   = 32'h4000 + 32'(4 * sent);
      st_data   = 32'h4444_0000 + 32'(sent);
      exp_ready = (model_cnt < DEPTH);
      exp_wr    = (model_cnt > 0) && !ld_req;
      @(negedge clk);
      check_eq("wrap_ready", {63'd0, st_ready}, {63'd0, exp_ready});
      check_eq("wrap_wr", {63'd0, MemWrite}, {63'd0, exp_wr});
      if (exp_ready) begin
        exp_q.push_back({st_addr, st_data});
        sent++;
      end
      model_cnt = model_cnt + int'(exp_ready) - int'(exp_wr);
      tick();
    end
    st_valid = 1'b0;
    drain_all(20);

    // reset with three stores pending discards them
    ld_req  = 1'b1;
    ld_addr = 32'h9000;
    for (int i = 0; i < 3; i++) begin
      put_store(32'h6000 + 32'(4 * i), 32'h6666_0000 + 32'(i));
      tick();
    end
    rst_n = 1'b0;
    set_idle();
    exp_q.delete();
    #1;
    check_eq("arst_empty", {63'd0, empty}, 64'd1);
    check_eq("arst_ready", {63'd0, st_ready}, 64'd1);
    check_eq("arst_wr", {63'd0, MemWrite}, 64'd0);
    check_eq("arst_adr", 64'(mem_adr), 64'd0);
    check_eq("arst_wdata", 64'(to_be_written_data), 64'd0);
    check_eq("arst_hit", {63'd0, ld_hit}, 64'd0);
    check_eq("arst_stall", {63'd0, ld_stall}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("arst_no_wr", {63'd0, MemWrite}, 64'd0);
      tick();
    end

    // final report
    check_eq("final_queue", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular store buffer between the core's memory stage and the data memory. Accepts stores at one per cycle, holds them in a small circular FIFO, and drains them into the memory's synchronous write port whenever the port is not needed by a load. Loads keep using the memory's combinational read path; this block only steers the shared address bus and, optionally, forwards buffered data to loads that hit a pending store.

## Interface
- DEPTH, 4: entries; power of two, 2..16.
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  core presents a store.
- st_addr  in  ADDR_W  store byte address; bits [1:0] ignored.
- st_data  in  DATA_W  store word.
- st_ready  out  1  store accepted on this edge when high with st_valid.
- ld_req  in  1  core performs a load this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_hit  out  1  ld_data valid; core uses it instead of memory read_data.
- ld_data  out  DATA_W  forwarded word.
- ld_stall  out  1  core must hold the load.
- fence  in  1  block new stores until buffer empty.
- empty  out  1  no pending stores.
- mem_adr  out  ADDR_W  shared memory address.
- to_be_written_data  out  DATA_W  memory write data.
- MemWrite  out  1  memory write enable.

## Operation
- Storage: DEPTH entries {word address = addr[ADDR_W-1:2], data}, head/tail pointers, count 0..DEPTH.
- Enqueue: st_valid && st_ready at posedge writes the tail entry. st_ready = (count < DEPTH) && !fence. No same-cycle bypass when full.
- Drain: MemWrite = !empty && (!ld_req || ld_stall). When MemWrite is high, the head entry pops on the same edge on which the memory writes it.
- Address mux: mem_adr = (ld_req && !ld_stall) ? ld_addr : {head word addr, 2'b00}. It is 0 when empty and there is no load.
- Simultaneous enqueue and drain: count is unchanged. Enqueue into an empty buffer reaches memory on the following cycle at the earliest.
- Match: a load matches an entry when the word addresses are equal. The youngest valid match wins. The entry being drained this cycle is still matchable.
- Stores and loads in the same cycle are excluded by the core. A same-cycle store is never forwarded.
- Pointers wrap modulo DEPTH. Count has width $clog2(DEPTH)+1.
- Reset mid-operation discards all pending stores. Memory keeps only stores already written.

## Timing
- Reset values: st_ready=1, MemWrite=0, empty=1, ld_hit=0, ld_data=0, ld_stall=0, mem_adr=0, to_be_written_data=0.
- All outputs are combinational from the registered state plus ld_req, ld_addr and fence. There is no registered output latency.
- Store-to-memory latency is at least 1 cycle. Under continuous loads it is unbounded unless ld_stall asserts.
- fence deasserts st_ready in the same cycle. empty rises on the edge after the last drain.

## Configuration
- STORE_BUF_FWD_EN defined: on a match, ld_hit=1 and ld_data = youngest matching data. ld_stall is held at 0.
- Not defined: ld_hit=0 and ld_data=0. On a match, ld_stall=1 and draining continues until no match remains. The load then proceeds with ld_stall=0.

## Structure
- Package store_buffer_pkg holds:
  - DEPTH default;
  - the entry struct typedef (word address, data);
  - the pointer-width localparam.
- Sub-module store_buffer_match: parallel comparators plus youngest-first priority select, given head, count and the entry array. It outputs match and the matching index.

## Test plan
- Reset, then stores to 0x1000/0x1004/0x1008 on consecutive cycles with ld_req=0 -> MemWrite on cycles 2–4 with matching mem_adr and data; empty=1 after.
- Fill 4 entries while ld_req=1 throughout -> st_ready=0 on the 5th store attempt and MemWrite=0. Drop ld_req -> 4 writes in order and st_ready returns after the first pop.
- With FWD_EN: stores 0x2000←0xAAAA, then 0x2000←0xBBBB. Load 0x2002 while both are pending -> ld_hit=1, ld_data=0xBBBB.
- Without FWD_EN: same sequence -> ld_stall=1 for 2 cycles while both entries drain, then ld_stall=0 and mem_adr=0x2002.
- Wrap-around: 10 stores interleaved with drains -> memory holds all 10 words in order; count never exceeds 4.
- Assert rst_n low with 3 entries pending -> all outputs return to reset values immediately and no further MemWrite occurs.
